// File: rtl/gpio_pkg.sv
// Shared register map for the Avalon-MM GPIO bank.
package gpio_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_IN       = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OUT      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd7;

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit input conditioner: synchroniser chain followed by a
// stable-time filter. The stable output only changes after the synchronised
// pin has disagreed with it for DEBOUNCE_CYCLES consecutive cycles; the
// change lands on the next edge. DEBOUNCE_CYCLES = 0 registers the
// synchronised value once.
module gpio_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic stable
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Metastability chain: pin enters at bit 0, leaves at the top bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // No filtering: one register stage after the synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stable <= 1'b0;
      else        stable <= synced;
    end
  end else begin : g_filter
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Count consecutive mismatch cycles; any agreeing cycle restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= synced;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/avalon_gpio_bank.sv
// Avalon-MM GPIO bank: debounced inputs with rise/fall edge capture and a
// maskable level interrupt, plus registered outputs with set/clear aliases.
module avalon_gpio_bank
  import gpio_pkg::*;
#(
  parameter int               WIDTH           = 10,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  // Bus protocol: slave without waitrequest. A write is accepted in every
  // cycle write is high. A read issued in cycle N returns its data on
  // readdata in cycle N+1; readdata is 0 in every cycle not following a
  // read. With read and write together the read returns the pre-write value.

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edges;
  logic [31:0]      rd_val;
  logic [31:0]      rd_q;
  logic             irq_q;
  logic             unused_wdata;

  // Bits at or above WIDTH are simply not stored
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .pin    (in_port[i]),
      .stable (stable[i])
    );
  end

  // Enabled transitions of the stable value seen one cycle after they occur
  assign edges = (stable & ~stable_d & rise_q) | (~stable & stable_d & fall_q);

  // Output register and its set/clear aliases
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q <= OUT_RESET;
    end else if (write) begin
      case (address)
        ADDR_OUT:     out_q <= wdata;
        ADDR_OUT_SET: out_q <= out_q | wdata;
        ADDR_OUT_CLR: out_q <= out_q & ~wdata;
        default:      ;
      endcase
    end
  end

  // Interrupt mask and edge-enable registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mask_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else if (write) begin
      case (address)
        ADDR_IRQ_MASK: mask_q <= wdata;
        ADDR_RISE_EN:  rise_q <= wdata;
        ADDR_FALL_EN:  fall_q <= wdata;
        default:       ;
      endcase
    end
  end

  // Edge capture: write-1-to-clear, a same-cycle new edge wins over the clear
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_d <= '0;
      cap_q    <= '0;
    end else begin
      stable_d <= stable;
      if (write && (address == ADDR_EDGE_CAP)) cap_q <= (cap_q & ~wdata) | edges;
      else                                     cap_q <= cap_q | edges;
    end
  end

  // Read mux over current register contents; write-only addresses read 0
  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_IN:       rd_val[WIDTH-1:0] = stable;
      ADDR_OUT:      rd_val[WIDTH-1:0] = out_q;
      ADDR_IRQ_MASK: rd_val[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAP: rd_val[WIDTH-1:0] = cap_q;
      ADDR_RISE_EN:  rd_val[WIDTH-1:0] = rise_q;
      ADDR_FALL_EN:  rd_val[WIDTH-1:0] = fall_q;
      default:       rd_val = '0;
    endcase
  end

  // Registered read data and interrupt level
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      rd_q  <= read ? rd_val : 32'd0;
      irq_q <= |(cap_q & mask_q);
    end
  end

  assign out_port = out_q;
  assign irq      = irq_q;
  assign readdata = rd_q;

endmodule

// File: tb/tb_avalon_gpio_bank.sv
// Bench for avalon_gpio_bank: a filtered 10-bit instance checked every cycle
// against a register-level model, plus a 32-bit bypass instance.
`timescale 1ns/1ps
module tb_avalon_gpio_bank;
  import gpio_pkg::*;

  localparam int              WA        = 10;
  localparam int              SA        = 2;
  localparam int              DA        = 8;
  localparam logic [WA-1:0]   OUT_RST_A = 10'h2A5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: WIDTH=10, DEBOUNCE=8 ----------------
  logic [2:0]    a_address   = 3'd0;
  logic          a_read      = 1'b0;
  logic          a_write     = 1'b0;
  logic [31:0]   a_writedata = 32'd0;
  logic [31:0]   a_readdata;
  logic [WA-1:0] a_in        = '0;
  logic [WA-1:0] a_out;
  logic          a_irq;

  avalon_gpio_bank #(
    .WIDTH(WA), .SYNC_STAGES(SA), .DEBOUNCE_CYCLES(DA), .OUT_RESET(OUT_RST_A)
  ) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .address(a_address), .read(a_read),
    .write(a_write), .writedata(a_writedata), .readdata(a_readdata),
    .in_port(a_in), .out_port(a_out), .irq(a_irq)
  );

  // ---------------- DUT B: WIDTH=32, bypass filter ----------------
  logic [2:0]  b_address   = 3'd0;
  logic        b_read      = 1'b1;
  logic        b_write     = 1'b0;
  logic [31:0] b_writedata = 32'd0;
  logic [31:0] b_readdata;
  logic [31:0] b_in        = 32'd0;
  logic [31:0] b_out;
  logic        b_irq;

  avalon_gpio_bank #(
    .WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)
  ) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .address(b_address), .read(b_read),
    .write(b_write), .writedata(b_writedata), .readdata(b_readdata),
    .in_port(b_in), .out_port(b_out), .irq(b_irq)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of DUT A ----------------
  // The stable value flips when the last DA+1 synchronised samples all
  // disagree with it; samples before reset release count as 0.
  logic [WA-1:0] m_stable, m_stable_prev, m_out, m_mask, m_cap, m_rise, m_fall;
  logic          m_irq;
  logic [31:0]   m_rd;
  logic [WA-1:0] m_hist[$];

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      ADDR_IN:       r[WA-1:0] = m_stable;
      ADDR_OUT:      r[WA-1:0] = m_out;
      ADDR_IRQ_MASK: r[WA-1:0] = m_mask;
      ADDR_EDGE_CAP: r[WA-1:0] = m_cap;
      ADDR_RISE_EN:  r[WA-1:0] = m_rise;
      ADDR_FALL_EN:  r[WA-1:0] = m_fall;
      default:       r = 32'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [WA-1:0] ns, ev, wd, cap_n;
    logic          irq_n;
    if (!rst_n) begin
      m_stable = '0; m_stable_prev = '0; m_out = OUT_RST_A; m_mask = '0;
      m_cap = '0; m_rise = '0; m_fall = '0; m_irq = 1'b0; m_rd = 32'd0;
      m_hist.delete();
    end else begin
      wd    = a_writedata[WA-1:0];
      m_rd  = a_read ? m_reg(a_address) : 32'd0;
      irq_n = |(m_cap & m_mask);
      ev    = (m_stable & ~m_stable_prev & m_rise) | (~m_stable & m_stable_prev & m_fall);
      m_hist.push_front(a_in);
      if (m_hist.size() > SA + DA + 1) void'(m_hist.pop_back());
      ns = m_stable;
      for (int b = 0; b < WA; b++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = SA; j <= SA + DA; j++) begin
          logic [WA-1:0] h;
          h = (j < m_hist.size()) ? m_hist[j] : '0;
          if (h[b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) ns[b] = ~m_stable[b];
      end
      cap_n = m_cap;
      if (a_write && a_address == ADDR_EDGE_CAP) cap_n = cap_n & ~wd;
      cap_n = cap_n | ev;
      if (a_write) begin
        case (a_address)
          ADDR_OUT:      m_out  = wd;
          ADDR_OUT_SET:  m_out  = m_out | wd;
          ADDR_OUT_CLR:  m_out  = m_out & ~wd;
          ADDR_IRQ_MASK: m_mask = wd;
          ADDR_RISE_EN:  m_rise = wd;
          ADDR_FALL_EN:  m_fall = wd;
          default:       ;
        endcase
      end
      m_cap         = cap_n;
      m_stable_prev = m_stable;
      m_stable      = ns;
      m_irq         = irq_n;
    end
  end

  // Every-cycle compare of DUT A against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_readdata", a_readdata, m_rd);
      check("cyc_out_port", 32'(a_out), 32'(m_out));
      check("cyc_irq", 32'(a_irq), 32'(m_irq));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    a_address = a; a_writedata = d; a_write = 1'b1;
    cyc();
    a_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    a_address = a; a_read = 1'b1;
    cyc();
    a_read = 1'b0;
    d = a_readdata;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [31:0] rd;
    cyc(3);
    check("rst_out_port", 32'(a_out), 32'h2A5);
    check("rst_irq", 32'(a_irq), 32'd0);
    rst_n = 1'b1;
    cyc();
    bus_read(ADDR_IN, rd);
    check("rst_read_in", rd, 32'd0);

    // Bypass instance: value appears at IN after SYNC_STAGES+1 edges,
    // readdata shows it one edge later
    b_in = 32'hDEAD_BEEF;
    for (int j = 1; j <= 5; j++) begin
      cyc();
      check("bypass_in", b_readdata, (j >= 4) ? 32'hDEAD_BEEF : 32'd0);
    end
    check("bypass_out", b_out, 32'd0);

    // Output register operations
    bus_write(ADDR_OUT, 32'h0F0);
    bus_write(ADDR_OUT_SET, 32'h003);
    bus_write(ADDR_OUT_CLR, 32'h010);
    check("out_ops_port", 32'(a_out), 32'h0E3);
    bus_read(ADDR_OUT, rd);
    check("out_ops_read", rd, 32'h0E3);
    bus_write(ADDR_OUT, 32'hFFFF_FC0F);
    check("out_wide_port", 32'(a_out), 32'h00F);
    bus_read(ADDR_OUT, rd);
    check("out_wide_read", rd, 32'h0000_000F);
    bus_read(ADDR_OUT_SET, rd);
    check("wo_read", rd, 32'd0);

    // Read and write in the same cycle return the old value
    a_address = ADDR_IRQ_MASK; a_writedata = 32'h155; a_write = 1'b1; a_read = 1'b1;
    cyc();
    a_write = 1'b0; a_read = 1'b0;
    check("rw_old", a_readdata, 32'd0);
    bus_read(ADDR_IRQ_MASK, rd);
    check("rw_new", rd, 32'h155);

    // Bounce on bit 0 every 3 cycles, then hold high
    a_address = ADDR_IN; a_read = 1'b1;
    for (int t = 0; t < 6; t++) begin
      a_in[0] = ~a_in[0];
      cyc(3);
    end
    a_in[0] = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      cyc();
      check("bounce_in0", 32'(a_readdata[0]), (j >= 12) ? 32'd1 : 32'd0);
    end
    a_read = 1'b0;

    // Rising edge on bit 1 captured and raising irq; W1C drops irq
    bus_write(ADDR_RISE_EN, 32'h2);
    bus_write(ADDR_IRQ_MASK, 32'h2);
    a_in[1] = 1'b1;
    cyc(12);
    check("rise_irq_pre", 32'(a_irq), 32'd0);
    cyc();
    check("rise_irq", 32'(a_irq), 32'd1);
    bus_read(ADDR_EDGE_CAP, rd);
    check("rise_cap", rd, 32'h2);
    bus_write(ADDR_EDGE_CAP, 32'h2);
    check("w1c_irq_1", 32'(a_irq), 32'd1);
    cyc();
    check("w1c_irq_2", 32'(a_irq), 32'd0);
    bus_read(ADDR_EDGE_CAP, rd);
    check("w1c_cap", rd, 32'd0);

    // Collision: fall sets cap[1]; W1C lands on the edge that captures the rise
    bus_write(ADDR_FALL_EN, 32'h2);
    a_in[1] = 1'b0;
    cyc(13);
    check("fall_irq", 32'(a_irq), 32'd1);
    bus_read(ADDR_EDGE_CAP, rd);
    check("fall_cap", rd, 32'h2);
    a_in[1] = 1'b1;
    cyc(11);
    a_address = ADDR_EDGE_CAP; a_writedata = 32'h2; a_write = 1'b1;
    cyc();
    a_write = 1'b0;
    check("coll_irq_1", 32'(a_irq), 32'd1);
    cyc();
    check("coll_irq_2", 32'(a_irq), 32'd1);
    bus_read(ADDR_EDGE_CAP, rd);
    check("coll_cap", rd, 32'h2);

    // Reset in the middle of a debounce on bit 2; inputs held high through it
    a_in[2] = 1'b1;
    cyc(6);
    rst_n = 1'b0;
    cyc(2);
    check("mid_rst_out", 32'(a_out), 32'h2A5);
    check("mid_rst_irq", 32'(a_irq), 32'd0);
    check("mid_rst_rd", a_readdata, 32'd0);
    rst_n = 1'b1;
    a_address = ADDR_IN; a_read = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      cyc();
      check("post_rst_in", a_readdata, (j >= 12) ? 32'h7 : 32'd0);
    end
    a_read = 1'b0;
    cyc();
    bus_read(ADDR_EDGE_CAP, rd);
    check("post_rst_cap", rd, 32'd0);
    check("post_rst_irq", 32'(a_irq), 32'd0);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_gpio_bank.md
AVALON_GPIO_BANK -- requirements
Module: avalon_gpio_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 10: number of input bits and number of output bits, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: length of the input synchroniser chain, legal range 2..3.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable-time filter length; 0 bypasses the filter.
REQ-004 SHALL have parameter OUT_RESET, default 0: reset value of out_port (WIDTH bits).
REQ-005 SHALL have port clk_clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 SHALL have port reset_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port address, input, 3 bits: Avalon-MM word address.
REQ-008 SHALL have ports read and write, input, 1 bit each: Avalon-MM strobes.
REQ-009 SHALL have port writedata, input, 32 bits; SHALL have port readdata, output, 32 bits.
REQ-010 SHALL have port in_port, input, WIDTH bits: asynchronous pins (keys, switches).
REQ-011 SHALL have port out_port, output, WIDTH bits: registered pins (LEDs, hex segments).
REQ-012 SHALL have port irq, output, 1 bit: level interrupt, registered.

Function
REQ-013 SHALL pass each in_port bit through SYNC_STAGES flops before any other use.
REQ-014 SHALL hold a per-bit stable value; it SHALL take the synchronised value after DEBOUNCE_CYCLES consecutive cycles of mismatch, and any agreeing cycle SHALL clear that bit's counter.
REQ-015 With DEBOUNCE_CYCLES=0, the stable value SHALL equal the synchronised value, registered once.
REQ-016 SHALL define the register map: 0 IN (RO, stable value); 1 OUT (RW); 2 OUT_SET (WO, OR into OUT); 3 OUT_CLR (WO, AND-NOT into OUT); 4 IRQ_MASK (RW); 5 EDGE_CAP (RO, write-1-to-clear); 6 RISE_EN (RW); 7 FALL_EN (RW).
REQ-017 SHALL use a fixed read latency of 1: readdata is valid the cycle after read; bits above WIDTH read 0; WO addresses read 0.
REQ-018 SHALL drive readdata to 0 in any cycle not following a read.
REQ-019 SHALL set EDGE_CAP[i] the cycle after stable[i] rises when RISE_EN[i]=1, or falls when FALL_EN[i]=1.
REQ-020 On a W1C to EDGE_CAP and a new edge on the same bit in the same cycle, the bit SHALL remain set.
REQ-021 SHALL drive irq = |(EDGE_CAP & IRQ_MASK), registered, i.e. one cycle after EDGE_CAP or IRQ_MASK changes.
REQ-022 SHALL apply OUT writes to out_port on the next clock edge, with no further delay.
REQ-023 When read and write are asserted together, the write SHALL take effect and readdata SHALL return the pre-write value.
REQ-024 Writes to bits at or above WIDTH SHALL be ignored.

Reset
REQ-025 On reset assertion: out_port=OUT_RESET; readdata=0; irq=0; IRQ_MASK, EDGE_CAP, RISE_EN and FALL_EN=0; synchroniser, stable values and counters=0.
REQ-026 A reset asserted mid-debounce SHALL discard the count; after release the filter SHALL restart from 0.
REQ-027 An input held high through reset SHALL produce a rising stable transition after release plus the sync and filter delay; it is captured only if RISE_EN is set by then.

Structure
REQ-028 SHALL place the register offsets (ADDR_IN .. ADDR_FALL_EN) and the address width in shared package gpio_pkg.
REQ-029 SHALL implement one sub-module gpio_debounce: single bit, synchroniser plus counter, instantiated WIDTH times via generate.

Verification
REQ-030 Reset: out_port = OUT_RESET (e.g. 0x2A5), irq=0, read of addr 0 returns 0.
REQ-031 Bounce: WIDTH=10, DEBOUNCE_CYCLES=8. Toggle in_port[0] every 3 cycles, then hold it at 1. IN[0] SHALL become 1 exactly 8+SYNC_STAGES+1 cycles after the last toggle and not before.
REQ-032 OUT ops: write OUT=0x0F0, then OUT_SET=0x003, then OUT_CLR=0x010; out_port SHALL read 0x0E3 and addr 1 SHALL read 0x0E3.
REQ-033 IRQ: RISE_EN=0x2, IRQ_MASK=0x2, drive a clean rising edge on in_port[1] -> EDGE_CAP=0x2, irq=1; write 0x2 to addr 5 -> irq=0 two cycles later.
REQ-034 Collision: W1C on EDGE_CAP bit 1 in the same cycle a new bit-1 edge is captured -> EDGE_CAP[1] remains 1 and irq stays 1.
REQ-035 Bypass: DEBOUNCE_CYCLES=0 and WIDTH=32. in_port=0xDEADBEEF -> IN reads 0xDEADBEEF SYNC_STAGES+1 cycles later.
